// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: debounce states, frame classes and
// the key-code width helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAND,
    HELD,
    REL
  } deb_state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_class_e;

  function automatic int code_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce FSM: accepts a key after DEB_FRAMES identical single-key
// frames and releases it after DEB_FRAMES empty (or ambiguous) frames.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int CW         = 4,
  parameter int DEB_FRAMES = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          frame_valid_i,
  input  frame_class_e  frame_class_i,
  input  logic [CW-1:0] frame_code_i,
  output logic          emit_o,
  output logic [CW-1:0] emit_code_o,
  output logic          held_o
);

  localparam logic [3:0] DEB_LAST = 4'(DEB_FRAMES);

  deb_state_e    state_q;
  logic [3:0]    cnt_q;
  logic [CW-1:0] cand_q;
  logic          emit_q;
  logic [CW-1:0] emit_code_q;
  logic          held_q;
  logic          single;

  // A frame with several keys down is ambiguous and counts as no key at all.
  assign single = (frame_class_i == SINGLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      emit_q      <= 1'b0;
      emit_code_q <= '0;
      held_q      <= 1'b0;
    end else begin
      emit_q <= 1'b0;
      if (frame_valid_i) begin
        unique case (state_q)
          IDLE: begin
            if (single) begin
              cand_q <= frame_code_i;
              cnt_q  <= 4'd1;
              if (DEB_LAST == 4'd1) begin
                state_q     <= HELD;
                held_q      <= 1'b1;
                emit_q      <= 1'b1;
                emit_code_q <= frame_code_i;
              end else begin
                state_q <= CAND;
              end
            end
          end
          CAND: begin
            if (single) begin
              if (frame_code_i == cand_q) begin
                if (cnt_q + 4'd1 == DEB_LAST) begin
                  state_q     <= HELD;
                  held_q      <= 1'b1;
                  emit_q      <= 1'b1;
                  emit_code_q <= cand_q;
                end else begin
                  cnt_q <= cnt_q + 4'd1;
                end
              end else begin
                cand_q <= frame_code_i;
                cnt_q  <= 4'd1;
              end
            end else begin
              state_q <= IDLE;
            end
          end
          HELD: begin
            if (!single) begin
              cnt_q <= 4'd1;
              if (DEB_LAST == 4'd1) begin
                state_q <= IDLE;
                held_q  <= 1'b0;
              end else begin
                state_q <= REL;
              end
            end
          end
          REL: begin
            // A key seen again while releasing is contact bounce, not a new press.
            if (single) begin
              state_q <= HELD;
            end else if (cnt_q + 4'd1 == DEB_LAST) begin
              state_q <= IDLE;
              held_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          default: begin
            state_q <= IDLE;
            held_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign emit_o      = emit_q;
  assign emit_code_o = emit_code_q;
  assign held_o      = held_q;

endmodule

// File: rtl/keypad_scan.sv
// Matrix keypad scanner: strobes one row low at a time, builds a frame image of
// the pressed keys, debounces it and hands one code per press to the consumer.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 2048,
  parameter int DEB_FRAMES = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic [ROWS-1:0]                   row_drv,
  input  logic [COLS-1:0]                   col_in,
  output logic [code_width(ROWS, COLS)-1:0] key_code,
  output logic                              key_valid,
  input  logic                              key_ready,
  output logic                              key_held,
  output logic                              overflow
);

  localparam int CW = code_width(ROWS, COLS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = $clog2(SCAN_DIV);

  logic [1:0]                 rst_sync_q;
  logic                       rst_int_n;
  logic [DW-1:0]              div_q, div_d;
  logic [RW-1:0]              row_q, row_d;
  logic [ROWS-1:0]            row_drv_q, row_drv_d;
  logic [COLS-1:0]            col_meta_q, col_sync_q;
  logic [ROWS-1:0][COLS-1:0]  image_q, image_d;
  logic                       sample_tick;
  logic                       frame_end;
  frame_class_e               frame_class;
  logic [CW-1:0]              frame_code;
  logic                       emit;
  logic [CW-1:0]              emit_code;
  logic                       held;
  logic [CW-1:0]              key_code_q;
  logic                       key_valid_q;
  logic                       overflow_q;

  // Reset asserts immediately but is released in step with clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n   = rst_sync_q[1];
  assign sample_tick = (div_q == DW'(SCAN_DIV - 1));
  assign frame_end   = sample_tick && (row_q == RW'(ROWS - 1));

  always_comb begin
    div_d = div_q + DW'(1);
    row_d = row_q;
    if (sample_tick) begin
      div_d = '0;
      row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
    end
    row_drv_d = ~(ROWS'(1) << row_d);
  end

  // Columns are sampled at the very end of each row slot to give the lines
  // the longest possible settling time after the row strobe moves.
  always_comb begin
    image_d = image_q;
    if (sample_tick) begin
      image_d[row_q] = ~col_sync_q;
    end
  end

  always_comb begin
    frame_class = NONE;
    frame_code  = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (image_d[r][c]) begin
          if (frame_class == NONE) begin
            frame_class = SINGLE;
            frame_code  = CW'(r * COLS + c);
          end else begin
            frame_class = MULTI;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      div_q      <= '0;
      row_q      <= '0;
      row_drv_q  <= ~ROWS'(1);
      col_meta_q <= '1;
      col_sync_q <= '1;
      image_q    <= '0;
    end else begin
      div_q      <= div_d;
      row_q      <= row_d;
      row_drv_q  <= row_drv_d;
      col_meta_q <= col_in;
      col_sync_q <= col_meta_q;
      image_q    <= image_d;
    end
  end

  keypad_debounce #(
    .CW         (CW),
    .DEB_FRAMES (DEB_FRAMES)
  ) u_debounce (
    .clk_i         (clk),
    .rst_n_i       (rst_int_n),
    .frame_valid_i (frame_end),
    .frame_class_i (frame_class),
    .frame_code_i  (frame_code),
    .emit_o        (emit),
    .emit_code_o   (emit_code),
    .held_o        (held)
  );

  // One-entry output buffer; a new key may replace one being consumed this cycle.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (emit) begin
        if (!key_valid_q || key_ready) begin
          key_code_q  <= emit_code;
          key_valid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (key_valid_q && key_ready) begin
        key_valid_q <= 1'b0;
      end
    end
  end

  assign row_drv   = row_drv_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = held;
  assign overflow  = overflow_q;

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix keypad scanner for the TicTacToe board: drives one keypad row low at a time, samples the active-low column lines, debounces over whole scan frames and hands one key code per press to the game logic over a valid/ready handshake. It is the input-side counterpart of the LED dot-matrix row scanner: same row-multiplexing scheme, but reading a matrix instead of writing one.

## Interface
- ROWS, 4, keypad rows scanned (2..8)
- COLS, 4, keypad columns sampled (2..8)
- SCAN_DIV, 2048, clk cycles each row stays driven (power of two, ≥4)
- DEB_FRAMES, 4, consecutive identical frames required to accept a press or release (1..15)
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- row_drv  output  ROWS  row strobes, active-low, exactly one bit low at all times
- col_in  input  COLS  column sense lines, active-low (external pull-ups), asynchronous
- key_code  output  $clog2(ROWS*COLS)  accepted key, row*COLS + col
- key_valid  output  1  key_code holds an unconsumed key
- key_ready  input  1  consumer accepts key_code when key_valid & key_ready
- key_held  output  1  debounced key currently down
- overflow  output  1  sticky: a press was dropped because the buffer was full

## Operation
- Row counter `row_idx` advances 0..ROWS-1 and wraps; divider counts 0..SCAN_DIV-1 per row. row_drv = all ones except bit row_idx low.
- col_in passes a 2-flop synchronizer. On divider == SCAN_DIV-1 the synchronized, inverted columns for row_idx are latched into the frame image (settling time = SCAN_DIV-3 cycles).
- At the end of the last row (frame end) classify the image: NONE (no bit set), SINGLE (exactly one bit, code computed), MULTI (two or more bits). MULTI is treated as NONE for acceptance and never produces a key.
- Debounce FSM, evaluated once per frame end:
  - IDLE: SINGLE → CAND (cand_code ← code, cnt ← 1); else stay.
  - CAND: SINGLE with same code → cnt+1; cnt reaching DEB_FRAMES → HELD and emit; different SINGLE → restart cnt=1 with new code; NONE/MULTI → IDLE.
  - HELD: NONE/MULTI → REL (cnt ← 1); SINGLE any code → stay (no new key until release).
  - REL: NONE/MULTI → cnt+1; reaching DEB_FRAMES → IDLE; SINGLE → HELD (bounce, no emit).
- key_held = 1 in HELD and REL.
- Emit: if key_valid = 0 or the buffer is being consumed in the same cycle, load key_code and assert key_valid; otherwise drop the key and set overflow.
- key_valid clears the cycle after key_valid & key_ready unless an emit occurs in that same cycle (emit wins, key_valid stays 1 with new code).
- overflow clears only on reset.

## Timing
- Reset (async assert, sync deassert inside block): row_idx=0, row_drv = ~1 (row 0 low), divider=0, FSM=IDLE, key_code=0, key_valid=0, key_held=0, overflow=0.
- row_drv is registered; changes on the cycle after divider wraps.
- Frame period = ROWS*SCAN_DIV cycles. Press stable from before a frame start is reported on key_valid 1 cycle after the DEB_FRAMES-th frame end; release latency identical.
- key_ready may be held high permanently; key_valid then pulses 1 cycle per key.
- Reset mid-frame discards image, candidate and buffered key.

## Structure
- keypad_pkg: FSM state enum (IDLE, CAND, HELD, REL), frame-class enum (NONE, SINGLE, MULTI), code-width function.
- Sub-module keypad_debounce: FSM + frame counter, input frame class/code, output emit pulse and held. Scanner, synchronizer, image and output buffer stay in keypad_scan.

## Test plan
Bench uses ROWS=4, COLS=4, SCAN_DIV=4, DEB_FRAMES=3 (frame = 16 cycles).
- Reset then idle 10 frames → row_drv cycles 1110,1101,1011,0111 every 4 cycles; key_valid, key_held, overflow stay 0.
- Model key (row 2, col 1) pulling col_in[1] low while row_drv[2]=0, held 5 frames, key_ready=1 → one key_valid pulse, key_code=9, key_held=1 until 3 frames after release.
- Same key bouncing (toggling every frame) for 4 frames then stable → exactly one key_code=9 after 3 stable frames.
- Keys 0 and 5 pressed together 6 frames → no key_valid (MULTI); release 5, keep 0 → key_code=0 after 3 frames.
- key_ready=0, press key 3, release, press key 7 → key_valid=1 with key_code=3, overflow=1; then key_ready=1 → key_valid drops next cycle.
- Assert rst_n=0 during CAND count 2 → all outputs at reset values immediately; after release of reset, press must again need 3 full frames.
